branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
- Parametrised successor to the single-cycle branch decision logic.
- Resolves all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in EX from ALU condition codes.
- Holds a PC-indexed table of 2-bit saturating counters that supplies a taken/not-taken prediction to IF.
- Flags mispredictions to the hazard unit and trains the table on each resolved branch.

Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, number of counters; must be a power of 2, minimum 2.
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).
- IDX_W, $clog2(BHT_ENTRIES), table index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  prediction for if_pc (combinational read).
- ex_valid  in  1  EX-stage instruction valid (not bubble/flushed).
- ex_opcode  in  7  EX instruction opcode.
- ex_funct3  in  3  EX instruction funct3.
- ex_cc  in  3  condition codes: [0] equal, [1] signed less-than, [2] unsigned less-than.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_branch  out  1  actual branch outcome (taken).
- ex_mispredict  out  1  outcome differs from the carried prediction.
- ex_illegal  out  1  B-type opcode with funct3 2 or 3.
- perf_branches  out  32  resolved-branch count.
- perf_misses  out  32  misprediction count.

Behaviour:
- B-type is opcode 7'b1100011. A branch is resolved when ex_valid & B-type & funct3 not in {2,3}.
- ex_branch decode, valid only on a resolved branch, else 0:
  - funct3 0 (BEQ): cc[0]
  - funct3 1 (BNE): ~cc[0]
  - funct3 4 (BLT): cc[1]
  - funct3 5 (BGE): ~cc[1]
  - funct3 6 (BLTU): cc[2]
  - funct3 7 (BGEU): ~cc[2]
- ex_illegal = ex_valid & B-type & funct3 in {2,3}. On an illegal branch: ex_branch=0, ex_mispredict=0, no table update.
- ex_mispredict = resolved & (ex_branch != ex_pred_taken). Combinational, same cycle; the hazard unit flushes IF/ID on it.
- Index: idx = pc[IDX_W+1:2] (word-aligned) for both if_pc and ex_pc.
- if_pred_taken = bht[idx(if_pc)][1]. Pure combinational read, zero latency.
- Update on a clk edge when resolved:
  - taken: counter +1, saturating at 2'b11.
  - not taken: counter -1, saturating at 2'b00.
  - Non-resolved cycles leave the table unchanged.
- Same-cycle read and write of the same index: IF sees the pre-update value, with no bypass. The new value is visible from the next cycle.
- Reset (asynchronous, any time, including mid-update): every counter is set to CTR_INIT and the perf counters to 0.
  - if_pred_taken then reflects CTR_INIT[1]; with the default this is 0.
  - Other outputs are combinational from inputs and need no reset value.
- X-safety: with ex_valid=0, all ex_* outputs are 0 regardless of the other ex_* inputs.

Optional Feature:
- Macro: BP_PERF_EN.
- Defined:
  - perf_branches increments by 1 on each clk edge with a resolved branch.
  - perf_misses increments by 1 on each edge with ex_mispredict=1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Undefined: the counters are not built, and perf_branches and perf_misses are tied to 0. Ports are present in both builds.

Test Plan:
- Reset defaults: assert rst mid-run after training idx 5 to 2'b11 -> if_pred_taken=0 for if_pc=0x14 immediately, without waiting for clk; perf_* = 0.
- Decode sweep: ex_valid=1, B-type, cc=3'b010, funct3 0/1/4/5/6/7 -> ex_branch = 0/1/1/0/0/1; funct3=2 -> ex_illegal=1, ex_branch=0, table unchanged.
- Saturation: ex_pc=0x40 taken 4 times from reset -> counter 01→10→11→11; if_pred_taken(0x40)=1. Then 4 not-taken -> 11→10→01→00→00, prediction flips to 0 after the second.
- Mispredict: ex_pred_taken=0, BNE with cc[0]=0 -> ex_branch=1, ex_mispredict=1; same with ex_valid=0 -> both 0, no update.
- Read/write collision: if_pc=ex_pc=0x80, counter 01, taken resolve -> if_pred_taken=0 in that cycle, 1 in the next cycle.
- Aliasing and counters: BHT_ENTRIES=4, train 0x00 taken twice -> if_pc=0x10 predicts taken. With BP_PERF_EN and 10 branches including 3 misses -> perf_branches=10, perf_misses=3; without the macro both read 0.

Source files
------------

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: RV32I branch resolution in EX plus a 2-bit saturating BHT predictor for IF; `BP_PERF_EN builds saturating perf counters.
module branch_predict_resolve #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [2:0]      ex_cc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            ex_branch,
  output logic            ex_mispredict,
  output logic            ex_illegal,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_misses
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic is_b, bad_f3, resolved, outcome;
  logic [1:0] ctr, ctr_nxt;
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign is_b = ex_opcode == 7'b1100011;
  assign bad_f3 = ex_funct3[2:1] == 2'b01;
  assign resolved = ex_valid & is_b & ~bad_f3;
  // funct3[2:1] picks eq/slt/ult, funct3[0] inverts the sense
  assign outcome = (ex_funct3[2] ? (ex_funct3[1] ? ex_cc[2] : ex_cc[1]) : ex_cc[0]) ^ ex_funct3[0];
  assign ex_branch = resolved & outcome;
  assign ex_mispredict = resolved & (outcome != ex_pred_taken);
  assign ex_illegal = ex_valid & is_b & bad_f3;
  assign if_pred_taken = bht[if_idx][1];
  always_comb begin
    ctr = bht[ex_idx];
    ctr_nxt = outcome ? (ctr == 2'b11 ? ctr : ctr + 2'b01) : (ctr == 2'b00 ? ctr : ctr - 2'b01);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    else if (resolved)
      bht[ex_idx] <= ctr_nxt;
`ifdef BP_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_branches <= '0;
      perf_misses <= '0;
    end else begin
      if (resolved && perf_branches != '1) perf_branches <= perf_branches + 32'd1;
      if (ex_mispredict && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
    end
`else
  assign perf_branches = '0;
  assign perf_misses = '0;
`endif
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: directed vectors for decode plus hand sequences for BHT training, collision, aliasing, perf and async reset.
module tb_branch_predict_resolve;
  localparam logic [6:0] B = 7'b1100011;
  logic clk = 0, rst = 1;
  logic [31:0] if_pc = 0, ex_pc = 0;
  logic ex_valid = 0, ex_pred_taken = 0;
  logic [6:0] ex_opcode = 0;
  logic [2:0] ex_funct3 = 0, ex_cc = 0;
  logic if_pred_taken, ex_branch, ex_mispredict, ex_illegal, pred4, br4, mis4, ill4;
  logic [31:0] perf_branches, perf_misses, pb4, pm4;
  int total = 0, bad = 0, exp_br = 0, exp_miss = 0;
  typedef struct {
    logic v; logic [6:0] op; logic [2:0] f3; logic [2:0] cc; logic pred;
    logic r; logic eb; logic em; logic ei;
  } vec_t;
  vec_t vt [13];
  always #5 clk = ~clk;
  branch_predict_resolve dut (.clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_cc(ex_cc), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_branch(ex_branch), .ex_mispredict(ex_mispredict),
    .ex_illegal(ex_illegal), .perf_branches(perf_branches), .perf_misses(perf_misses));
  branch_predict_resolve #(.BHT_ENTRIES(4)) dut4 (.clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred4),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_cc(ex_cc), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_branch(br4), .ex_mispredict(mis4),
    .ex_illegal(ill4), .perf_branches(pb4), .perf_misses(pm4));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic br_set(input logic [31:0] pc, input logic taken, input logic pred);
    ex_valid = 1; ex_opcode = B; ex_funct3 = 3'd0; ex_cc = {2'b00, taken}; ex_pc = pc; ex_pred_taken = pred;
    exp_br++;
    if (taken != pred) exp_miss++;
  endtask
  task automatic tick();
    @(posedge clk); #1;
    ex_valid = 0;
  endtask
  initial begin
    logic [3:0] sat_t, sat_n;
    vt[0]  = '{1, B, 3'd0, 3'b010, 0, 1, 0, 0, 0};
    vt[1]  = '{1, B, 3'd1, 3'b010, 0, 1, 1, 1, 0};
    vt[2]  = '{1, B, 3'd4, 3'b010, 0, 1, 1, 1, 0};
    vt[3]  = '{1, B, 3'd5, 3'b010, 0, 1, 0, 0, 0};
    vt[4]  = '{1, B, 3'd6, 3'b010, 0, 1, 0, 0, 0};
    vt[5]  = '{1, B, 3'd7, 3'b010, 0, 1, 1, 1, 0};
    vt[6]  = '{1, B, 3'd2, 3'b010, 0, 0, 0, 0, 1};
    vt[7]  = '{1, B, 3'd3, 3'b111, 1, 0, 0, 0, 1};
    vt[8]  = '{0, B, 3'd1, 3'b000, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 7'b0110011, 3'd1, 3'b000, 0, 0, 0, 0, 0};
    vt[10] = '{1, B, 3'd1, 3'b000, 0, 1, 1, 1, 0};
    vt[11] = '{1, B, 3'd1, 3'b000, 1, 1, 1, 0, 0};
    vt[12] = '{1, B, 3'd0, 3'b001, 1, 1, 1, 0, 0};
    sat_t = 4'b1111;
    sat_n = 4'b0001;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    if_pc = 32'h14; #1;
    chk("reset_pred", {31'd0, if_pred_taken}, 0);
    chk("reset_perf_b", perf_branches, 0);
    chk("reset_perf_m", perf_misses, 0);
    chk("reset_ex_out", {29'd0, ex_branch, ex_mispredict, ex_illegal}, 0);
    br_set(32'h00, 1, 0); tick();
    br_set(32'h00, 1, 1); tick();
    if_pc = 32'h10; #1;
    chk("alias4_pred", {31'd0, pred4}, 1);
    chk("noalias64_pred", {31'd0, if_pred_taken}, 0);
    br_set(32'h14, 1, 0); tick();
    br_set(32'h14, 1, 1); tick();
    if_pc = 32'h14; #1;
    chk("train14_pred", {31'd0, if_pred_taken}, 1);
    for (int i = 0; i < 13; i++) begin
      ex_valid = vt[i].v; ex_opcode = vt[i].op; ex_funct3 = vt[i].f3; ex_cc = vt[i].cc;
      ex_pred_taken = vt[i].pred; ex_pc = 32'h2C; #1;
      chk($sformatf("vec%0d_branch", i), {31'd0, ex_branch}, {31'd0, vt[i].eb});
      chk($sformatf("vec%0d_mis", i), {31'd0, ex_mispredict}, {31'd0, vt[i].em});
      chk($sformatf("vec%0d_ill", i), {31'd0, ex_illegal}, {31'd0, vt[i].ei});
      if (vt[i].r) exp_br++;
      if (vt[i].em) exp_miss++;
      tick();
    end
    if_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      br_set(32'h40, 1, 1); tick();
      chk($sformatf("sat_taken%0d", i), {31'd0, if_pred_taken}, {31'd0, sat_t[i]});
    end
    for (int i = 0; i < 4; i++) begin
      br_set(32'h40, 0, 1); tick();
      chk($sformatf("sat_ntaken%0d", i), {31'd0, if_pred_taken}, {31'd0, sat_n[i]});
    end
    if_pc = 32'h80;
    br_set(32'h80, 1, 0); #1;
    chk("collide_same", {31'd0, if_pred_taken}, 0);
    chk("collide_mis", {31'd0, ex_mispredict}, 1);
    tick();
    chk("collide_next", {31'd0, if_pred_taken}, 1);
    if_pc = 32'h30;
    br_set(32'h30, 1, 1); tick();
    ex_valid = 1; ex_opcode = B; ex_funct3 = 3'd2; ex_cc = 3'b000; ex_pc = 32'h30; ex_pred_taken = 0; #1;
    chk("ill_flag", {31'd0, ex_illegal}, 1);
    tick();
    ex_valid = 1; ex_funct3 = 3'd3; ex_cc = 3'b111; tick();
    chk("ill_nodec", {31'd0, if_pred_taken}, 1);
    br_set(32'h30, 0, 0); tick();
    chk("ill_noinc", {31'd0, if_pred_taken}, 0);
`ifdef BP_PERF_EN
    chk("perf_branches", perf_branches, exp_br);
    chk("perf_misses", perf_misses, exp_miss);
`else
    chk("perf_branches", perf_branches, 0);
    chk("perf_misses", perf_misses, 0);
`endif
    if_pc = 32'h14; #1;
    chk("pre_rst_pred", {31'd0, if_pred_taken}, 1);
    br_set(32'h14, 1, 1);
    #2 rst = 1; #1;
    chk("async_rst_pred", {31'd0, if_pred_taken}, 0);
    chk("async_rst_pb", perf_branches, 0);
    chk("async_rst_pm", perf_misses, 0);
    tick();
    chk("rst_held_pred", {31'd0, if_pred_taken}, 0);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
